leaky_bucket_counter_bank: RTL

- Parametrised multi-channel successor to the single decaying saturation counter.
- Holds CHANNELS independent leaky-bucket counters. Each counter:
  - grows on a per-channel strobe;
  - decays on a shared internally generated periodic tick;
  - saturates exactly at a programmable ceiling;
  - trips/releases with hysteresis.
- Used for per-source error/activity rate monitoring, e.g. per-lane glitch or clock-loss event rates feeding alarm logic.

---
 rtl/leaky_bucket_counter_bank.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/leaky_bucket_counter_bank.sv
// leaky_bucket_counter_bank: CHANNELS independent leaky-bucket counters.
// Each counter grows on its strobe and leaks on a shared prescaled tick.
// It saturates at a programmable ceiling and trips/releases with hysteresis.
// Optional: define LEAKY_BUCKET_TRIP_COUNT_EN to add trip_counts_o, which is a
// saturating per-channel count of entries into TRIPPED.
// Interface: inc_i/clear_i are level-sampled on every rising clock edge. There
// is no valid/ready handshake. Config inputs are used live and never latched.
// state_dbg_o[2c +: 2] shows channel c's FSM state: 0 IDLE, 1 COUNTING, 2 TRIPPED.

package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

module leaky_bucket_counter_bank #(
  parameter int CHANNELS     = 4,
  parameter int BIT_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 16
) (
  input  common_p::clk_dom_s          clk_dom_i,
  input  logic [CHANNELS-1:0]         inc_i,
  input  logic [CHANNELS-1:0]         clear_i,
  input  logic                        decay_en_i,
  input  logic [PERIOD_WIDTH-1:0]     decay_period_i,
  input  logic [BIT_WIDTH-1:0]        growth_rate_i,
  input  logic [BIT_WIDTH-1:0]        decay_rate_i,
  input  logic [BIT_WIDTH-1:0]        saturation_limit_i,
  input  logic                        plateau_en_i,
  input  logic [BIT_WIDTH-1:0]        plateau_limit_i,
  input  logic [BIT_WIDTH-1:0]        trip_level_i,
  input  logic [BIT_WIDTH-1:0]        release_level_i,
  output logic                        decay_tick_o,
  output logic [CHANNELS*BIT_WIDTH-1:0] counts_o,
  output logic [CHANNELS-1:0]         tripped_o,
  output logic [CHANNELS-1:0]         trip_pulse_o,
  output logic [2*CHANNELS-1:0]       state_dbg_o
`ifdef LEAKY_BUCKET_TRIP_COUNT_EN
  ,
  output logic [CHANNELS*8-1:0]       trip_counts_o
`endif
);

  localparam int SW = BIT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_TRIPPED  = 2'd2
  } state_e;

  logic clk;
  logic rst_n;
  assign clk   = clk_dom_i.clk;
  assign rst_n = clk_dom_i.rst_n;

  logic [PERIOD_WIDTH-1:0] presc_q;
  logic                    tick;
  logic [SW-1:0]           floor_w;
  logic [SW-1:0]           sum_w      [CHANNELS];
  logic [SW-1:0]           leak_w     [CHANNELS];
  logic [BIT_WIDTH-1:0]    count_q    [CHANNELS];
  logic [BIT_WIDTH-1:0]    count_next [CHANNELS];
  state_e                  state_q    [CHANNELS];
  state_e                  state_next [CHANNELS];
  logic [CHANNELS-1:0]     entry;
  logic [CHANNELS-1:0]     pulse_q;

  // Decay tick fires when the running prescaler matches the programmed period
  always_comb begin
    tick    = decay_en_i && (presc_q == decay_period_i);
    floor_w = plateau_en_i ? {1'b0, plateau_limit_i} : '0;
  end

  // Prescaler: held at zero while disabled, wraps on a tick or at its natural width
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      decay_tick_o <= 1'b0;
    end else begin
      decay_tick_o <= tick;
      if (!decay_en_i || tick) presc_q <= '0;
      else                     presc_q <= presc_q + PERIOD_WIDTH'(1);
    end
  end

  // Next count: add growth, leak toward the floor, clamp to the ceiling, clear wins
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_w[c]  = {1'b0, count_q[c]} + (inc_i[c] ? {1'b0, growth_rate_i} : '0);
      leak_w[c] = sum_w[c];
      if (tick && (sum_w[c] > floor_w)) begin
        if (sum_w[c] >= ({1'b0, decay_rate_i} + floor_w))
          leak_w[c] = sum_w[c] - {1'b0, decay_rate_i};
        else
          leak_w[c] = floor_w;
      end
      if (leak_w[c] > {1'b0, saturation_limit_i})
        count_next[c] = saturation_limit_i;
      else
        count_next[c] = leak_w[c][BIT_WIDTH-1:0];
      if (clear_i[c])
        count_next[c] = '0;
    end
  end

  // Next state: the trip threshold is checked first so trip_level 0 holds TRIPPED
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_next[c] = state_q[c];
      if (clear_i[c]) begin
        state_next[c] = ST_IDLE;
      end else if (count_next[c] >= trip_level_i) begin
        state_next[c] = ST_TRIPPED;
      end else begin
        case (state_q[c])
          ST_IDLE:     if (count_next[c] != '0) state_next[c] = ST_COUNTING;
          ST_COUNTING: if (count_next[c] == '0) state_next[c] = ST_IDLE;
          ST_TRIPPED: begin
            if (count_next[c] == '0)                 state_next[c] = ST_IDLE;
            else if (count_next[c] < release_level_i) state_next[c] = ST_COUNTING;
          end
          default:     state_next[c] = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs: pack counts, decode state, flag TRIPPED entries for the pulse register
  always_comb begin
    counts_o     = '0;
    tripped_o    = '0;
    state_dbg_o  = '0;
    entry        = '0;
    trip_pulse_o = pulse_q;
    for (int c = 0; c < CHANNELS; c++) begin
      counts_o[c*BIT_WIDTH +: BIT_WIDTH] = count_q[c];
      tripped_o[c]         = (state_q[c] == ST_TRIPPED);
      state_dbg_o[2*c +: 2] = state_q[c];
      entry[c]             = (state_next[c] == ST_TRIPPED) && (state_q[c] != ST_TRIPPED);
    end
  end

  // Per-channel count, state and entry-pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
        state_q[c] <= ST_IDLE;
      end
    end else begin
      pulse_q <= entry;
      for (int c = 0; c < CHANNELS; c++) begin
        count_q[c] <= count_next[c];
        state_q[c] <= state_next[c];
      end
    end
  end

`ifdef LEAKY_BUCKET_TRIP_COUNT_EN
  logic [7:0] trip_cnt_q [CHANNELS];

  // Saturating count of TRIPPED entries; updates on the edge the pulse rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) trip_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clear_i[c])                             trip_cnt_q[c] <= '0;
        else if (entry[c] && (trip_cnt_q[c] != 8'hFF)) trip_cnt_q[c] <= trip_cnt_q[c] + 8'd1;
      end
    end
  end

  // Pack trip-entry counters
  always_comb begin
    trip_counts_o = '0;
    for (int c = 0; c < CHANNELS; c++) trip_counts_o[c*8 +: 8] = trip_cnt_q[c];
  end
`endif

  // Hysteresis requires release at or below trip; flag illegal programming
  a_release_le_trip: assert property (@(posedge clk) disable iff (!rst_n)
    release_level_i <= trip_level_i)
    else $error("release_level_i above trip_level_i");

endmodule
